// File: rtl/game_pkg.sv
// Shared definitions for the game display path: coordinate widths, sprite IDs and the
// commit FSM state encoding.
package game_pkg;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  localparam logic [1:0] SPR_PLAYER = 2'd0;
  localparam logic [1:0] SPR_ENEMY  = 2'd1;
  localparam logic [1:0] SPR_BULLET = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCommit = 2'd1,
    StDone   = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fall_det.sv
// Two-flop synchroniser for an asynchronous level input followed by a registered
// one-cycle pulse on each falling edge of the synchronised value.
module sync_fall_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
    fall_d = prev_q & ~sync_q;
  end

  // Chain resets high so an idle-high input does not fake an edge on reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/sprite_commit_ctrl.sv
// Sprite position commit controller: processor writes land in shadow registers and dirty
// entries are copied to the renderer-visible registers only at vertical blank.
module sprite_commit_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_SPR   = 3,
  parameter int unsigned X_W       = game_pkg::X_W,
  parameter int unsigned Y_W       = game_pkg::Y_W,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic                   master_clk,
  input  logic                   resetn,
  input  logic                   vga_vsync,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [1:0]             wr_id,
  input  logic [X_W-1:0]         wr_x,
  input  logic [Y_W-1:0]         wr_y,
  output logic [NUM_SPR*X_W-1:0] act_x,
  output logic [NUM_SPR*Y_W-1:0] act_y,
  output logic [NUM_SPR-1:0]     dirty,
  output logic                   commit_pulse,
  output logic [15:0]            frame_cnt,
  output logic                   err_id,
  output logic                   overrun
);

  localparam int unsigned     IdxW    = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_SPR - 1);
  localparam logic [7:0]      DivLast = 8'(FRAME_DIV - 1);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [NUM_SPR*X_W-1:0] sh_x_q, sh_x_d, act_x_q, act_x_d;
  logic [NUM_SPR*Y_W-1:0] sh_y_q, sh_y_d, act_y_q, act_y_d;
  logic [NUM_SPR-1:0]     dirty_q, dirty_d;
  logic [7:0]             div_q, div_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   err_q, err_d;
  logic                   ovr_q, ovr_d;
  logic                   vb_edge, eligible, wr_fire;

  sync_fall_det u_vsync_det (
    .clk_i  (master_clk),
    .rst_ni (resetn),
    .async_i(vga_vsync),
    .fall_o (vb_edge)
  );

  assign wr_ready = (state_q == StIdle);
  assign wr_fire  = wr_valid & wr_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sh_x_d      = sh_x_q;
    sh_y_d      = sh_y_q;
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    dirty_d     = dirty_q;
    div_d       = div_q;
    frame_cnt_d = frame_cnt_q;
    pulse_d     = 1'b0;
    err_d       = err_q;
    ovr_d       = ovr_q;
    eligible    = 1'b0;

    // Frame counting and division run in every state.
    if (vb_edge) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (div_q == DivLast) begin
        div_d    = 8'd0;
        eligible = 1'b1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end

    // Out-of-range IDs complete the handshake but only raise the sticky error.
    if (wr_fire) begin
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
        if (32'(wr_id) == i) begin
          sh_x_d[i*X_W +: X_W] = wr_x;
          sh_y_d[i*Y_W +: Y_W] = wr_y;
          dirty_d[i]           = 1'b1;
        end
      end
      if (32'(wr_id) >= NUM_SPR) begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (eligible) begin
          state_d = StCommit;
          idx_d   = '0;
        end
      end
      StCommit: begin
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
          if ((32'(idx_q) == i) && dirty_q[i]) begin
            act_x_d[i*X_W +: X_W] = sh_x_q[i*X_W +: X_W];
            act_y_d[i*Y_W +: Y_W] = sh_y_q[i*Y_W +: Y_W];
            dirty_d[i]            = 1'b0;
          end
        end
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        if (vb_edge) begin
          ovr_d = 1'b1;
        end
      end
      StDone: begin
        pulse_d = 1'b1;
        state_d = StIdle;
        if (vb_edge) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      sh_x_q      <= '0;
      sh_y_q      <= '0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      dirty_q     <= '0;
      div_q       <= 8'd0;
      frame_cnt_q <= 16'd0;
      pulse_q     <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sh_x_q      <= sh_x_d;
      sh_y_q      <= sh_y_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      dirty_q     <= dirty_d;
      div_q       <= div_d;
      frame_cnt_q <= frame_cnt_d;
      pulse_q     <= pulse_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
    end
  end

  assign act_x        = act_x_q;
  assign act_y        = act_y_q;
  assign dirty        = dirty_q;
  assign commit_pulse = pulse_q;
  assign frame_cnt    = frame_cnt_q;
  assign err_id       = err_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_sprite_commit_ctrl.sv
// Bench for sprite_commit_ctrl: two instances (divide by 1 and by 2) share stimulus and
// are compared against a per-instance behavioural model of shadow/active sprite state.
module tb_sprite_commit_ctrl;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        vga_vsync;
  logic        wr_valid;
  logic [1:0]  wr_id;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic        wr_ready_a, wr_ready_b;
  logic [29:0] act_x_a, act_x_b;
  logic [26:0] act_y_a, act_y_b;
  logic [2:0]  dirty_a, dirty_b;
  logic        commit_pulse_a, commit_pulse_b;
  logic [15:0] frame_cnt_a, frame_cnt_b;
  logic        err_id_a, err_id_b, overrun_a, overrun_b;

  int checks = 0;
  int errors = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  always #5 clk = ~clk;

  sprite_commit_ctrl #(.NUM_SPR(3), .X_W(10), .Y_W(9), .FRAME_DIV(1)) dut_a (
    .master_clk(clk), .resetn(resetn), .vga_vsync(vga_vsync), .wr_valid(wr_valid),
    .wr_ready(wr_ready_a), .wr_id(wr_id), .wr_x(wr_x), .wr_y(wr_y), .act_x(act_x_a),
    .act_y(act_y_a), .dirty(dirty_a), .commit_pulse(commit_pulse_a),
    .frame_cnt(frame_cnt_a), .err_id(err_id_a), .overrun(overrun_a)
  );

  sprite_commit_ctrl #(.NUM_SPR(3), .X_W(10), .Y_W(9), .FRAME_DIV(2)) dut_b (
    .master_clk(clk), .resetn(resetn), .vga_vsync(vga_vsync), .wr_valid(wr_valid),
    .wr_ready(wr_ready_b), .wr_id(wr_id), .wr_x(wr_x), .wr_y(wr_y), .act_x(act_x_b),
    .act_y(act_y_b), .dirty(dirty_b), .commit_pulse(commit_pulse_b),
    .frame_cnt(frame_cnt_b), .err_id(err_id_b), .overrun(overrun_b)
  );

  always @(negedge clk) begin
    if (commit_pulse_a === 1'b1) pulses_a++;
    if (commit_pulse_b === 1'b1) pulses_b++;
  end

  // Reference model: index 0 = divide-by-1 instance, 1 = divide-by-2 instance.
  localparam int FDIV [2] = '{1, 2};
  logic [9:0]  m_sx [3];
  logic [8:0]  m_sy [3];
  logic [9:0]  m_ax [2][3];
  logic [8:0]  m_ay [2][3];
  logic [2:0]  m_dirty [2];
  logic [15:0] m_fc [2];
  int          m_div [2];
  logic        m_err;
  logic        m_ovr [2];
  int          m_pulses [2] = '{0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_sx[i] = '0; m_sy[i] = '0;
      for (int n = 0; n < 2; n++) begin m_ax[n][i] = '0; m_ay[n][i] = '0; end
    end
    for (int n = 0; n < 2; n++) begin
      m_dirty[n] = '0; m_fc[n] = '0; m_div[n] = 0; m_ovr[n] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic m_write(input int id, input logic [9:0] x, input logic [8:0] y);
    if (id >= 3) begin
      m_err = 1'b1;
    end else begin
      m_sx[id] = x; m_sy[id] = y;
      m_dirty[0][id] = 1'b1; m_dirty[1][id] = 1'b1;
    end
  endtask

  task automatic m_vb(input int n, input bit busy, output bit committed);
    bit elig;
    m_fc[n] = m_fc[n] + 16'd1;
    m_div[n] = m_div[n] + 1;
    elig = (m_div[n] == FDIV[n]);
    if (elig) m_div[n] = 0;
    committed = 1'b0;
    if (busy) begin
      m_ovr[n] = 1'b1;
    end else if (elig) begin
      for (int i = 0; i < 3; i++) begin
        if (m_dirty[n][i]) begin m_ax[n][i] = m_sx[i]; m_ay[n][i] = m_sy[i]; end
      end
      m_dirty[n] = '0;
      m_pulses[n]++;
      committed = 1'b1;
    end
  endtask

  function automatic logic [29:0] pk_x(input int n);
    for (int i = 0; i < 3; i++) pk_x[i*10 +: 10] = m_ax[n][i];
  endfunction

  function automatic logic [26:0] pk_y(input int n);
    for (int i = 0; i < 3; i++) pk_y[i*9 +: 9] = m_ay[n][i];
  endfunction

  function automatic logic [29:0] mix_x(input logic [29:0] o, input logic [29:0] nw, input int k);
    mix_x = o;
    for (int i = 0; i < k; i++) mix_x[i*10 +: 10] = nw[i*10 +: 10];
  endfunction

  function automatic logic [26:0] mix_y(input logic [26:0] o, input logic [26:0] nw, input int k);
    mix_y = o;
    for (int i = 0; i < k; i++) mix_y[i*9 +: 9] = nw[i*9 +: 9];
  endfunction

  task automatic check_all();
    chk("act_x_a", act_x_a, pk_x(0));       chk("act_y_a", act_y_a, pk_y(0));
    chk("act_x_b", act_x_b, pk_x(1));       chk("act_y_b", act_y_b, pk_y(1));
    chk("dirty_a", dirty_a, m_dirty[0]);    chk("dirty_b", dirty_b, m_dirty[1]);
    chk("frame_cnt_a", frame_cnt_a, m_fc[0]); chk("frame_cnt_b", frame_cnt_b, m_fc[1]);
    chk("err_id_a", err_id_a, m_err);       chk("err_id_b", err_id_b, m_err);
    chk("overrun_a", overrun_a, m_ovr[0]);  chk("overrun_b", overrun_b, m_ovr[1]);
    chk("pulses_a", pulses_a, m_pulses[0]); chk("pulses_b", pulses_b, m_pulses[1]);
  endtask

  // Called at a negedge with both instances idle.
  task automatic do_write(input int id, input logic [9:0] x, input logic [8:0] y);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_id = id[1:0]; wr_x = x; wr_y = y;
    while (!wr_ready_a && n < 20) begin @(negedge clk); n++; end
    chk("write_ready", wr_ready_a, 1'b1);
    @(negedge clk);
    wr_valid = 1'b0;
    m_write(id, x, y);
  endtask

  // One vsync falling edge; optionally hold a write request from the first COMMIT cycle.
  task automatic vblank(input bit hold, input int hid, input logic [9:0] hx, input logic [8:0] hy);
    logic [29:0] ox_a, nx_a, ox_b, nx_b;
    logic [26:0] oy_a, ny_a, oy_b, ny_b;
    bit ca, cb, acc_next, accepted;
    int rlow_a, rlow_b, pulse_at;
    ox_a = pk_x(0); oy_a = pk_y(0); ox_b = pk_x(1); oy_b = pk_y(1);
    m_vb(0, 1'b0, ca);
    m_vb(1, 1'b0, cb);
    nx_a = pk_x(0); ny_a = pk_y(0); nx_b = pk_x(1); ny_b = pk_y(1);
    rlow_a = 0; rlow_b = 0; pulse_at = -1; acc_next = 0; accepted = 0;
    @(negedge clk);
    vga_vsync = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!wr_ready_a) rlow_a++;
      if (!wr_ready_b) rlow_b++;
      if (commit_pulse_a) pulse_at = k;
      if (k >= 3 && k <= 7) begin
        chk("stage_act_x_a", act_x_a, mix_x(ox_a, nx_a, k - 3));
        chk("stage_act_y_a", act_y_a, mix_y(oy_a, ny_a, k - 3));
        chk("stage_act_x_b", act_x_b, mix_x(ox_b, nx_b, k - 3));
        chk("stage_act_y_b", act_y_b, mix_y(oy_b, ny_b, k - 3));
      end
      if (acc_next) begin wr_valid = 1'b0; acc_next = 0; accepted = 1; end
      if (hold && k == 3) begin
        wr_valid = 1'b1; wr_id = hid[1:0]; wr_x = hx; wr_y = hy;
      end
      if (wr_valid && wr_ready_a) acc_next = 1;
    end
    if (acc_next) begin wr_valid = 1'b0; accepted = 1; end
    chk("ready_low_a", rlow_a, 4);
    chk("ready_low_b", rlow_b, cb ? 4 : 0);
    chk("pulse_cycle_a", pulse_at, 7);
    if (hold) begin
      chk("held_write_accepted", accepted, 1'b1);
      m_write(hid, hx, hy);
    end
    vga_vsync = 1'b1;
    repeat (4) @(negedge clk);
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit c0, c1, dummy;
    resetn = 1'b0; vga_vsync = 1'b1; wr_valid = 1'b0; wr_id = '0; wr_x = '0; wr_y = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("ready_in_reset", wr_ready_a, 1'b1);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", wr_ready_a, 1'b1);
    check_all();

    // Single write to the enemy sprite, then one vblank.
    do_write(int'(SPR_ENEMY), 10'd200, 9'd100);
    repeat (3) @(negedge clk);
    chk("dirty_pending", dirty_a, 3'b010);
    vblank(1'b0, 0, '0, '0);

    // Last write wins.
    do_write(int'(SPR_PLAYER), 10'd50, 9'd7);
    do_write(int'(SPR_PLAYER), 10'd60, 9'd7);
    vblank(1'b0, 0, '0, '0);
    chk("last_write_wins", act_x_a[9:0], 10'd60);

    // Write held across a commit lands afterwards.
    vblank(1'b1, int'(SPR_BULLET), 10'd300, 9'd40);
    chk("held_write_dirty", dirty_a, 3'b100);
    vblank(1'b0, 0, '0, '0);

    // Out-of-range ID.
    do_write(3, 10'd999, 9'd255);
    chk("err_id_set", err_id_a, 1'b1);
    vblank(1'b0, 0, '0, '0);

    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) do_write($urandom_range(0, 3), 10'($urandom), 9'($urandom));
      vblank(($urandom_range(0, 3) == 0), $urandom_range(0, 2), 10'($urandom), 9'($urandom));
    end

    // Second vsync edge arrives while committing.
    do_write($urandom_range(0, 2), 10'($urandom), 9'($urandom));
    m_vb(0, 1'b0, c0); m_vb(0, c0, dummy);
    m_vb(1, 1'b0, c1); m_vb(1, c1, dummy);
    @(negedge clk) vga_vsync = 1'b0;
    @(negedge clk) vga_vsync = 1'b1;
    @(negedge clk) vga_vsync = 1'b0;
    repeat (14) @(negedge clk);
    vga_vsync = 1'b1;
    repeat (4) @(negedge clk);
    check_all();
    chk("overrun_set", overrun_a, 1'b1);

    // Frame counter wrap from a preloaded all-ones value.
    force dut_a.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_a.frame_cnt_q;
    m_fc[0] = 16'hFFFF;
    @(negedge clk);
    chk("frame_cnt_preload", frame_cnt_a, 16'hFFFF);
    vblank(1'b0, 0, '0, '0);
    chk("frame_cnt_wrap", frame_cnt_a, 16'h0000);

    // Reset in the middle of a commit.
    do_write(int'(SPR_PLAYER), 10'd77, 9'd33);
    @(negedge clk) vga_vsync = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_act_x", act_x_a, '0);       chk("rst_act_y", act_y_a, '0);
    chk("rst_dirty", dirty_a, '0);       chk("rst_pulse", commit_pulse_a, 1'b0);
    chk("rst_frame_cnt", frame_cnt_a, '0); chk("rst_err_id", err_id_a, 1'b0);
    chk("rst_overrun", overrun_a, 1'b0); chk("rst_ready", wr_ready_a, 1'b1);
    chk("rst_act_x_b", act_x_b, '0);     chk("rst_frame_cnt_b", frame_cnt_b, '0);
    vga_vsync = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    m_reset();
    repeat (4) @(negedge clk);
    check_all();
    do_write(int'(SPR_ENEMY), 10'd321, 9'd123);
    vblank(1'b0, 0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
